// File: rtl/router_pkg.sv
// Shared constants and FSM state type for the router arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   NUM_DST  number of router destination ports
//   DST_W    width of a destination index
//   state_t  arbiter FSM state {IDLE, LOCKED}
package router_pkg;

  localparam int NUM_DST = 4;
  localparam int DST_W   = 2;

  // IDLE: round-robin arbitration among eligible requesters.
  // LOCKED: a multi-beat packet owns the router until its last beat.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of elig searching upward from ptr+1, wrapping.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; found=0 simply means no candidate this cycle.
//
// Ports:
//   elig   [N-1:0]   candidate mask, bit i set when requester i may be granted
//   ptr    [IW-1:0]  index of the most recent winner (highest current priority is ptr+1)
//   found            at least one bit of elig is set
//   index  [IW-1:0]  winning index, 0 when found=0
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Walk offsets 1..N from ptr; the first hit is kept because later hits
  // are gated by found.  Offset N wraps back to ptr itself, so the previous
  // winner is served again only when nobody else is eligible.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!found && elig[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/router_arb.sv
// Packet arbiter: round-robin among requesters, holds the router for a whole packet.
// Latency: 1 cycle from accepted beat (valid & ready at an edge) to din/din_en.
// Backpressure: req_ready drops for any requester whose destination is busy; a locked
//               packet stalls (bubbles) while its destination is busy or its owner is idle.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/ready      per-requester beat handshake (ready is combinational)
//   req_data/addr/last   per-requester payload, destination 0..3, end-of-packet flag
//   dst_busy             per-destination stall from the router
//   din/din_en/addr      registered beat to the router (all zero when no beat)
//   grant_id             registered index of the requester that sourced din
module router_arb
  import router_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*DST_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_DST-1:0]            dst_busy,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          din_en,
  output logic [DST_W-1:0]              addr,
  output logic [IW-1:0]                 grant_id
);

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       owner_q;
  logic [DST_W-1:0]    lock_addr_q;

  logic [DST_W-1:0]      addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;

  logic                win_found;
  logic [IW-1:0]       win_idx;

  logic                xfer;
  logic                xfer_last;
  logic [IW-1:0]       src_idx;
  logic [DST_W-1:0]    xfer_addr;

  // Unpack the flat per-requester buses and form the IDLE eligibility mask.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_a[g] = req_addr[g*DST_W +: DST_W];
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign elig[g]   = req_valid[g] & ~dst_busy[addr_a[g]];
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .found (win_found),
    .index (win_idx)
  );

  // In LOCKED the owner's own req_addr is ignored; the destination latched
  // on the first beat steers every following beat of the packet.
  assign src_idx   = (state_q == IDLE) ? win_idx : owner_q;
  assign xfer_addr = (state_q == IDLE) ? addr_a[win_idx] : lock_addr_q;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_last = req_last[src_idx];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer && !xfer_last) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && xfer_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (req_ready)
  // Derived only from state, valids, busies and addresses, never from
  // req_ready itself.  Forced to zero while reset is asserted.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = '0;
    if (resetn) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            req_ready[win_idx] = 1'b1;
          end
        end
        LOCKED: begin
          // Busy on any other destination is irrelevant here.
          req_ready[owner_q] = req_valid[owner_q] & ~dst_busy[lock_addr_q];
        end
        default: req_ready = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration context: priority pointer and packet lock
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= IW'(NUM_REQ - 1);
      owner_q     <= '0;
      lock_addr_q <= '0;
    end else if (state_q == IDLE && xfer) begin
      // ptr only advances on a real grant; with no eligible requester it holds.
      ptr_q <= win_idx;
      if (!xfer_last) begin
        owner_q     <= win_idx;
        lock_addr_q <= addr_a[win_idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered beat to the router; everything returns to zero on idle
  // cycles so downstream never sees stale payload or source ids.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din      <= '0;
      din_en   <= 1'b0;
      addr     <= '0;
      grant_id <= '0;
    end else if (xfer) begin
      din      <= data_a[src_idx];
      din_en   <= 1'b1;
      addr     <= xfer_addr;
      grant_id <= src_idx;
    end else begin
      din      <= '0;
      din_en   <= 1'b0;
      addr     <= '0;
      grant_id <= '0;
    end
  end

endmodule

// File: tb/tb_router_arb.sv
// Self-checking bench for router_arb: directed scenarios plus randomized traffic
// compared every cycle against a packet-level reference model.
// Runs with default parameters (32-bit data, 4 requesters).
module tb_router_arb;

  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*2-1:0]  req_addr;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [3:0]      dst_busy;
  logic [DW-1:0]   din;
  logic            din_en;
  logic [1:0]      addr;
  logic [1:0]      grant_id;

  int checks;
  int errors;

  router_arb #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .req_ready (req_ready),
    .dst_busy  (dst_busy),
    .din       (din),
    .din_en    (din_en),
    .addr      (addr),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Packet view: either free (next grant = first valid requester with a
  // free destination after the last winner) or held by one packet.
  bit          m_locked;
  logic [1:0]  m_owner;
  logic [1:0]  m_lock_addr;
  logic [1:0]  m_ptr;
  logic [DW-1:0] e_din;
  logic        e_en;
  logic [1:0]  e_addr;
  logic [1:0]  e_gid;

  function automatic logic [1:0] addr_of(input int i);
    return req_addr[i*2 +: 2];
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    bit found;
    int j;
    r = '0;
    found = 0;
    if (resetn) begin
      if (!m_locked) begin
        for (int k = 1; k <= N; k++) begin
          j = (int'(m_ptr) + k) % N;
          if (!found && req_valid[j] && !dst_busy[addr_of(j)]) begin
            found = 1;
            r[j] = 1'b1;
          end
        end
      end else begin
        r[m_owner] = req_valid[m_owner] && !dst_busy[m_lock_addr];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked    = 0;
    m_owner     = 2'd0;
    m_lock_addr = 2'd0;
    m_ptr       = 2'(N - 1);
    e_din       = '0;
    e_en        = 1'b0;
    e_addr      = 2'd0;
    e_gid       = 2'd0;
  endtask

  // Called exactly at a rising edge, with the inputs as the DUT sees them.
  task automatic model_step();
    logic [N-1:0] r;
    int j;
    if (!resetn) begin
      model_reset();
      return;
    end
    r = model_ready();
    j = -1;
    for (int i = 0; i < N; i++) begin
      if (r[i] && req_valid[i]) j = i;
    end
    if (j >= 0) begin
      e_din  = req_data[j*DW +: DW];
      e_en   = 1'b1;
      e_addr = m_locked ? m_lock_addr : addr_of(j);
      e_gid  = 2'(j);
      if (!m_locked) begin
        m_ptr = 2'(j);
        if (!req_last[j]) begin
          m_locked    = 1;
          m_owner     = 2'(j);
          m_lock_addr = addr_of(j);
        end
      end else if (req_last[j]) begin
        m_locked = 0;
      end
    end else begin
      e_din  = '0;
      e_en   = 1'b0;
      e_addr = 2'd0;
      e_gid  = 2'd0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_step();
    if (!resetn) model_reset();
    chk("model req_ready", 64'(req_ready), 64'(model_ready()));
    chk("model din_en",    64'(din_en),    64'(e_en));
    chk("model din",       64'(din),       64'(e_din));
    chk("model addr",      64'(addr),      64'(e_addr));
    chk("model grant_id",  64'(grant_id),  64'(e_gid));
  endtask

  task automatic chk_out(input string name, input logic en, input logic [DW-1:0] d,
                         input logic [1:0] a, input logic [1:0] g);
    chk({name, " din_en"},   64'(din_en),   64'(en));
    chk({name, " din"},      64'(din),      64'(d));
    chk({name, " addr"},     64'(addr),     64'(a));
    chk({name, " grant_id"}, 64'(grant_id), 64'(g));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] a,
                         input logic l, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*2 +: 2]   = a;
    req_last[i]          = l;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_data  = '0;
    req_addr  = '0;
    req_last  = '0;
    dst_busy  = '0;
  endtask

  task automatic reset_dut();
    tick();
    resetn = 1'b0;
    clear_inputs();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] oh;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    clear_inputs();
    model_reset();

    fork
      forever begin
        @(negedge clk);
        compare_step();
        @(posedge clk);
        model_step();
      end
    join_none

    // Reset state
    #2;
    chk_out("reset", 1'b0, '0, 2'd0, 2'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    resetn = 1'b1;

    // 1: all four requesting single beats -> grants 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'(i), 1'b1, DW'(32'hA0 + i));
    for (int k = 0; k < 5; k++) begin
      look();
      oh = 4'b0001;
      oh = oh << (k % 4);
      chk("rr ready", 64'(req_ready), 64'(oh));
      if (k > 0) chk_out("rr out", 1'b1, DW'(32'hA0 + (k - 1) % 4), 2'((k - 1) % 4), 2'((k - 1) % 4));
    end
    look();
    chk_out("rr wrap", 1'b1, 32'hA0, 2'd0, 2'd0);

    // 2: req0 3-beat burst to dst 2 blocks req1 until its last beat
    reset_dut();
    set_req(0, 1'b1, 2'd2, 1'b0, 32'h11);
    set_req(1, 1'b1, 2'd1, 1'b1, 32'h22);
    look(); chk("burst first ready", 64'(req_ready), 64'h1);
    tick();
    set_req(0, 1'b1, 2'd3, 1'b0, 32'h12);
    look(); chk_out("burst beat1", 1'b1, 32'h11, 2'd2, 2'd0);
    chk("burst req1 blocked a", 64'(req_ready), 64'h1);
    tick();
    set_req(0, 1'b1, 2'd0, 1'b1, 32'h13);
    look(); chk_out("burst beat2", 1'b1, 32'h12, 2'd2, 2'd0);
    chk("burst req1 blocked b", 64'(req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h0);
    look(); chk_out("burst beat3", 1'b1, 32'h13, 2'd2, 2'd0);
    chk("burst req1 ready", 64'(req_ready), 64'h2);
    tick();
    look(); chk_out("burst req1 beat", 1'b1, 32'h22, 2'd1, 2'd1);
    tick();

    // 3: locked destination busy for two cycles -> two bubbles, still locked
    reset_dut();
    set_req(0, 1'b1, 2'd2, 1'b0, 32'h31);
    set_req(1, 1'b1, 2'd2, 1'b1, 32'h41);
    tick();
    dst_busy = 4'b0100;
    set_req(0, 1'b1, 2'd2, 1'b0, 32'h32);
    look(); chk("busy ready", 64'(req_ready), 64'h0);
    tick();
    look(); chk_out("bubble 1", 1'b0, '0, 2'd0, 2'd0);
    tick();
    dst_busy = 4'b0000;
    look(); chk_out("bubble 2", 1'b0, '0, 2'd0, 2'd0);
    chk("resume still locked", 64'(req_ready), 64'h1);
    tick();
    set_req(0, 1'b1, 2'd2, 1'b1, 32'h33);
    look(); chk_out("resume beat2", 1'b1, 32'h32, 2'd2, 2'd0);
    tick();
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h0);
    look(); chk_out("resume beat3", 1'b1, 32'h33, 2'd2, 2'd0);
    tick();

    // 4: busy destination skips req1, req2 wins, pointer moves to 2
    reset_dut();
    dst_busy = 4'b1000;
    set_req(1, 1'b1, 2'd3, 1'b1, 32'h51);
    set_req(2, 1'b1, 2'd0, 1'b1, 32'h52);
    look(); chk("skip ready", 64'(req_ready), 64'h4);
    tick();
    set_req(2, 1'b0, 2'd0, 1'b0, 32'h0);
    set_req(0, 1'b1, 2'd0, 1'b1, 32'h50);
    set_req(3, 1'b1, 2'd1, 1'b1, 32'h53);
    look(); chk_out("skip grant", 1'b1, 32'h52, 2'd0, 2'd2);
    chk("ptr=2 next ready", 64'(req_ready), 64'h8);
    tick();
    look(); chk_out("after ptr2", 1'b1, 32'h53, 2'd1, 2'd3);
    tick();

    // 5: reset in the middle of a 4-beat burst
    reset_dut();
    set_req(0, 1'b1, 2'd1, 1'b0, 32'h61);
    set_req(1, 1'b1, 2'd2, 1'b1, 32'h71);
    tick();
    set_req(0, 1'b1, 2'd1, 1'b0, 32'h62);
    tick();
    resetn = 1'b0;
    set_req(0, 1'b0, 2'd0, 1'b0, 32'h0);
    #1;
    chk_out("midburst reset", 1'b0, '0, 2'd0, 2'd0);
    chk("midburst reset ready", 64'(req_ready), 64'h0);
    tick();
    resetn = 1'b1;
    look(); chk("post reset ready", 64'(req_ready), 64'h2);
    tick();
    look(); chk_out("post reset grant", 1'b1, 32'h71, 2'd2, 2'd1);
    tick();

    // 6: idle, no requests
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      look(); chk_out("idle", 1'b0, '0, 2'd0, 2'd0);
    end
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0, DW'($urandom));
      end
      for (int d = 0; d < 4; d++) dst_busy[d] = $urandom_range(0, 3) == 0;
    end
    tick();
    clear_inputs();
    look();
    look();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
